// File: rtl/out_channel_pkg.sv
// Shared definitions for the output-channel drain block.
package out_channel_pkg;

    localparam int DEFAULT_MEM_W = 12;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/out_channel_drain_if.sv
// Handshake and status bundle between the executor, the drain block and its consumer.
interface out_channel_drain_if #(
    parameter int MemoryElementWidth = out_channel_pkg::DEFAULT_MEM_W,
    parameter int NDepth             = 16,
    parameter int NCount             = 16
);
    localparam int CW = $clog2(NDepth) + 1;

    logic                          in_valid;
    logic [MemoryElementWidth-1:0] in_data;
    logic                          in_ready;
    logic                          finished;
    logic                          out_valid;
    logic [MemoryElementWidth-1:0] out_data;
    logic                          out_ready;
    logic [CW-1:0]                 count;
    logic [NCount-1:0]             total;
    logic                          overflow;
    logic                          drained;

    modport slave (
        input  in_valid, in_data, finished, out_ready,
        output in_ready, out_valid, out_data, count, total, overflow, drained
    );

    modport master (
        output in_valid, in_data, finished, out_ready,
        input  in_ready, out_valid, out_data, count, total, overflow, drained
    );

endinterface

// File: rtl/out_channel_fifo.sv
// Power-of-two FIFO with distributed-RAM storage and an asynchronous read port.
module out_channel_fifo #(
    parameter int Width = 12,
    parameter int Depth = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [Width-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [Width-1:0]         rd_data,
    output logic [$clog2(Depth):0]   count
);
    localparam int AW = $clog2(Depth);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [Width-1:0] mem [Depth];

    // Callers only write when not full and only read when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    // Gate the read so stale storage never shows while empty or in reset.
    assign rd_data = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count   = count_q;

endmodule

// File: rtl/out_channel_drain.sv
// Buffers out-instruction words and tracks end-of-run draining, totals and overflow.
module out_channel_drain
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEFAULT_MEM_W,
    parameter int NDepth             = 16,
    parameter int NCount             = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    out_channel_drain_if.slave  bus
);
    localparam int CW = $clog2(NDepth) + 1;

    state_e            state_q, state_d;
    logic [NCount-1:0] total_q, total_d;
    logic              overflow_q, overflow_d;
    logic              drained_q, drained_d;

    logic [CW-1:0]                 fifo_count;
    logic [MemoryElementWidth-1:0] fifo_rd_data;
    logic                          in_ready;
    logic                          out_valid;
    logic                          accept;
    logic                          consume;
    logic                          empty_after;

    // Depends only on registered state, never on out_ready.
    assign in_ready  = (state_q == RUN) && (fifo_count < CW'(NDepth));
    assign out_valid = (fifo_count != '0);
    assign accept    = bus.in_valid && in_ready;
    assign consume   = out_valid && bus.out_ready;
    assign empty_after = (fifo_count == '0) || ((fifo_count == CW'(1)) && consume);

    out_channel_fifo #(
        .Width (MemoryElementWidth),
        .Depth (NDepth)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_data (bus.in_data),
        .rd_en   (consume),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        overflow_d = overflow_q | (bus.in_valid && !in_ready);
        if (accept && (total_q != '1)) total_d = total_q + NCount'(1);
        case (state_q)
            RUN:     if (bus.finished) state_d = FLUSH;
            FLUSH:   if (empty_after)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
        drained_d = drained_q | (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            total_q    <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
            drained_q  <= drained_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = fifo_rd_data;
    assign bus.count     = fifo_count;
    assign bus.total     = total_q;
    assign bus.overflow  = overflow_q;
    assign bus.drained   = drained_q;

endmodule

// File: tb/tb_out_channel_drain.sv
// Directed bench for out_channel_drain: fill, overflow, full-buffer contention, flush and reset.
module tb_out_channel_drain;
    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    out_channel_drain_if #(.MemoryElementWidth(12), .NDepth(16), .NCount(16)) bus ();

    out_channel_drain #(
        .MemoryElementWidth (12),
        .NDepth             (16),
        .NCount             (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.finished = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_total",     32'(bus.total),     32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        chk("rst_drained",   32'(bus.drained),   32'd0);
        reset_n = 1'b1;
        step();

        // Five words straight through
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            step();
            chk("pass_valid", 32'(bus.out_valid), 32'd1);
            chk("pass_data",  32'(bus.out_data),  32'(i));
            chk("pass_count", 32'(bus.count),     32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("pass_total",    32'(bus.total),    32'd5);
        chk("pass_overflow", 32'(bus.overflow), 32'd0);
        chk("pass_empty",    32'(bus.count),    32'd0);

        // Fill to 16 with the consumer stalled, then offer a 17th word
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(100 + i);
            step();
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count",    32'(bus.count),    32'd16);
        chk("full_ovf_pre",  32'(bus.overflow), 32'd0);
        bus.in_data = 12'd999;
        step();
        chk("full_overflow", 32'(bus.overflow), 32'd1);
        chk("full_count2",   32'(bus.count),    32'd16);
        chk("full_total",    32'(bus.total),    32'd21);

        // Full buffer with simultaneous offer and consume: only the consume happens
        chk("full_head", 32'(bus.out_data), 32'd100);
        bus.in_data   = 12'd500;
        bus.out_ready = 1'b1;
        step();
        chk("contend_count", 32'(bus.count), 32'd15);
        chk("contend_total", 32'(bus.total), 32'd21);
        bus.in_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", 32'(bus.out_data), 32'(100 + i));
            step();
        end
        chk("drain_empty",  32'(bus.out_valid), 32'd0);
        chk("drain_count",  32'(bus.count),     32'd0);
        chk("drain_sticky", 32'(bus.overflow),  32'd1);

        // Three buffered words, then finished with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            step();
        end
        bus.in_valid = 1'b0;
        bus.finished = 1'b1;
        step();
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        chk("flush_count",    32'(bus.count),    32'd3);
        chk("flush_drained",  32'(bus.drained),  32'd0);
        bus.out_ready = 1'b1;
        chk("flush_d0", 32'(bus.out_data), 32'd7);
        step();
        chk("flush_d1", 32'(bus.out_data), 32'd8);
        chk("flush_not_done", 32'(bus.drained), 32'd0);
        step();
        chk("flush_d2", 32'(bus.out_data), 32'd9);
        chk("flush_not_done2", 32'(bus.drained), 32'd0);
        step();
        chk("done_drained",  32'(bus.drained),  32'd1);
        chk("done_count",    32'(bus.count),    32'd0);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        chk("done_total",    32'(bus.total),    32'd24);

        // Reset, buffer 8 words, then reset mid-stream
        bus.finished  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        chk("rerun_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(40 + i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_count", 32'(bus.count), 32'd8);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.count),     32'd0);
        chk("mid_rst_total", 32'(bus.total),     32'd0);
        chk("mid_rst_data",  32'(bus.out_data),  32'd0);
        #1;
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd77;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data",  32'(bus.out_data),  32'd77);
        chk("post_rst_count", 32'(bus.count),     32'd1);
        chk("post_rst_total", 32'(bus.total),     32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(bus.count), 32'd0);

        // finished on an idle, empty channel
        bus.finished = 1'b1;
        chk("idle_drained0", 32'(bus.drained), 32'd0);
        step();
        chk("idle_drained1", 32'(bus.drained), 32'd0);
        step();
        chk("idle_drained2", 32'(bus.drained), 32'd1);
        chk("idle_total",    32'(bus.total),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_channel_drain.md
OUT_CHANNEL_DRAIN -- requirements
Module: out_channel_drain

Interface
REQ-001 The block SHALL have parameter MemoryElementWidth, default 12, the data word width.
REQ-002 The block SHALL have parameter NDepth, default 16, the buffer depth in words; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter NCount, default 16, the width of the total-words counter.
REQ-004 Port clock  input  1  the single clock; all state changes on the rising edge.
REQ-005 Port reset_n  input  1  the reset; asynchronous, active-low.
REQ-006 Port in_valid  input  1  the executor presents an out-instruction word.
REQ-007 Port in_data  input  MemoryElementWidth  the word to output.
REQ-008 Port in_ready  output  1  the buffer can accept a word.
REQ-009 Port finished  input  1  the executor has finished; level, sampled every cycle.
REQ-010 Port out_valid  output  1  out_data holds a valid word.
REQ-011 Port out_data  output  MemoryElementWidth  the head-of-buffer word.
REQ-012 Port out_ready  input  1  the downstream consumer accepts out_data.
REQ-013 Port count  output  $clog2(NDepth)+1  the number of words buffered.
REQ-014 Port total  output  NCount  the number of words accepted since reset, saturating at all-ones.
REQ-015 Port overflow  output  1  sticky: in_valid was seen while in_ready was low.
REQ-016 Port drained  output  1  finished was seen and every accepted word has been consumed.

Function
REQ-017 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high, and consumed on one where out_valid and out_ready are both high.
REQ-018 Buffering SHALL be first-in first-out, with read and write pointers that wrap modulo NDepth.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL be the oldest word, stable while out_valid is high and out_ready is low.
REQ-020 Latency from acceptance into an empty buffer to out_valid high SHALL be one cycle; there is no input-to-output combinational path.
REQ-021 in_ready SHALL be high when count < NDepth and the state is RUN, and low in every other case; in_ready SHALL NOT depend combinationally on out_ready.
REQ-022 If an accept and a consume occur in the same cycle, count SHALL be unchanged.
REQ-023 A consume in the same cycle as a full buffer SHALL NOT admit a word that cycle.
REQ-024 A word offered when in_ready is low SHALL be dropped and SHALL set overflow, which stays high until reset.
REQ-025 The state machine SHALL have three states, and its transitions SHALL be:
  - RUN: accepts words. Moves to FLUSH on finished=1.
  - FLUSH: in_ready low; emits the remaining words. Moves to DONE when count is 0 after that cycle's consume.
  - DONE: drained=1; no accepts; stays until reset.
REQ-026 When finished=1 arrives with count=0, the block SHALL go RUN to FLUSH to DONE, so drained is high two edges after finished is sampled.
REQ-027 A word offered in the same cycle that finished is first sampled SHALL still be accepted.
REQ-028 total SHALL increment by exactly 1 per accepted word, and SHALL hold at 2^NCount-1 once it saturates.

Reset
REQ-029 While reset_n is low, the block SHALL asynchronously clear to:
  - state = RUN;
  - both pointers, count, total, overflow and drained = 0;
  - out_valid = 0; out_data = 0;
  - in_ready = 1.
REQ-030 An assertion of reset_n mid-stream SHALL discard all buffered words; nothing buffered before reset SHALL appear after it.
REQ-031 Buffer storage SHALL NOT require reset.
REQ-032 Release of reset SHALL take effect at the first rising edge of clock after release.

Structure
REQ-033 A shared package out_channel_pkg SHALL hold:
  - the default MemoryElementWidth;
  - the state enumeration RUN / FLUSH / DONE.
REQ-034 The FIFO storage and pointers SHALL be one sub-module, out_channel_fifo; the state machine, total counter, overflow flag and drained flag SHALL live in out_channel_drain.
REQ-035 Storage SHALL be inferable as distributed RAM, read asynchronously at the read pointer.

Verification
REQ-036 Reset, then 5 words 1..5 with out_ready=1 -> out_data sequence 1,2,3,4,5 each one cycle after accept; total=5; overflow=0.
REQ-037 out_ready=0, 16 words 100..115, then a 17th word 999 -> in_ready low after the 16th; overflow=1; count=16; the drain then yields 100..115 only.
REQ-038 Buffer full with simultaneous in_valid and out_ready -> count goes to 15, no word is accepted that cycle, and word order is preserved.
REQ-039 3 words buffered, out_ready=0, finished=1 -> in_ready=0; raising out_ready yields 3 words; drained=1 on the edge after the last consume.
REQ-040 reset_n pulsed low while 8 words are buffered -> out_valid=0 and count=0 immediately; total=0; the next accepted word is the first one out.
REQ-041 finished=1 with an empty buffer and an idle stream -> drained=1 exactly two edges later; total unchanged.
